// File: rtl/mem_arbiter.sv
// Two-port SRAM arbiter (0 = calculator controller, 1 = host loader) with burst lock; MEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority.
// Latency: grant and SRAM strobe in the request cycle, rvalid/rdata one cycle later.
// Backpressure: a requester holds its command until granted; a locked owner is preempted after LOCK_MAX beats if the other port waits.
package calculator_pkg;
  localparam int ADDR_W        = 8;
  localparam int MEM_WORD_SIZE = 8;
endpackage

module mem_arbiter #(
  parameter int ADDR_W        = calculator_pkg::ADDR_W,
  parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE,
  parameter int LOCK_MAX      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_0,
  input  logic                     we_0,
  input  logic                     lock_0,
  input  logic [ADDR_W-1:0]        addr_0,
  input  logic [MEM_WORD_SIZE-1:0] wdata_0,
  output logic                     gnt_0,
  output logic                     rvalid_0,
  output logic [MEM_WORD_SIZE-1:0] rdata_0,
  input  logic                     req_1,
  input  logic                     we_1,
  input  logic                     lock_1,
  input  logic [ADDR_W-1:0]        addr_1,
  input  logic [MEM_WORD_SIZE-1:0] wdata_1,
  output logic                     gnt_1,
  output logic                     rvalid_1,
  output logic [MEM_WORD_SIZE-1:0] rdata_1,
  output logic                     mem_read_n,
  output logic                     mem_write_n,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [MEM_WORD_SIZE-1:0] mem_wdata,
  input  logic [MEM_WORD_SIZE-1:0] mem_rdata
);

  localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LOCK_MAX);
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit PREEMPT_OWN0 = 1'b0;
`else
  localparam bit PREEMPT_OWN0 = 1'b1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             cnt_full;
  logic             gnt0_c, gnt1_c;
  logic             tie_to_1;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign tie_to_1 = 1'b0;
`else
  logic rr_q, rr_d;
  assign tie_to_1 = rr_q;
`endif

  // The counter covers the whole tenure, the beat that took the lock included.
  assign cnt_full = (cnt_q >= CNT_LIM);
  assign cnt_inc  = cnt_full ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_0 && (!req_1 || !tie_to_1)) begin
          gnt0_c = 1'b1;
          if (lock_0) begin
            state_d = S_OWN0;
            cnt_d   = CNT_W'(1);
          end
        end else if (req_1) begin
          gnt1_c = 1'b1;
          if (lock_1) begin
            state_d = S_OWN1;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_OWN0: begin
        if (PREEMPT_OWN0 && cnt_full && req_1) begin
          state_d = S_IDLE;
        end else if (req_0) begin
          gnt0_c = 1'b1;
          cnt_d  = cnt_inc;
          if (!lock_0 || (PREEMPT_OWN0 && (cnt_inc >= CNT_LIM) && req_1))
            state_d = S_IDLE;
        end else if (!lock_0) begin
          state_d = S_IDLE;
        end
      end
      S_OWN1: begin
        if (cnt_full && req_0) begin
          state_d = S_IDLE;
        end else if (req_1) begin
          gnt1_c = 1'b1;
          cnt_d  = cnt_inc;
          if (!lock_1 || ((cnt_inc >= CNT_LIM) && req_0))
            state_d = S_IDLE;
        end else if (!lock_1) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifndef MEM_ARB_FIXED_PRIO_EN
  // Pointer always lands on the port that did not just get service.
  always_comb begin
    rr_d = rr_q;
    if (gnt0_c)
      rr_d = 1'b1;
    else if (gnt1_c)
      rr_d = 1'b0;
    else if (state_q == S_OWN0 && state_d == S_IDLE)
      rr_d = 1'b1;
    else if (state_q == S_OWN1 && state_d == S_IDLE)
      rr_d = 1'b0;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_0 <= gnt0_c && !we_0;
      rvalid_1 <= gnt1_c && !we_1;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_q     <= rr_d;
`endif
    end
  end

  // Grants are masked by reset so the SRAM sees no strobe while rst_ni is low.
  assign gnt_0 = gnt0_c && rst_ni;
  assign gnt_1 = gnt1_c && rst_ni;

  assign mem_read_n  = !((gnt_0 && !we_0) || (gnt_1 && !we_1));
  assign mem_write_n = !((gnt_0 && we_0) || (gnt_1 && we_1));
  assign mem_addr    = gnt_0 ? addr_0  : (gnt_1 ? addr_1  : '0);
  assign mem_wdata   = gnt_0 ? wdata_0 : (gnt_1 ? wdata_1 : '0);

  assign rdata_0 = mem_rdata;
  assign rdata_1 = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for arbitration/read-write, hand sequences for lock, preemption and reset.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       req_0, we_0, lock_0, req_1, we_1, lock_1;
  logic [7:0] addr_0, wdata_0, addr_1, wdata_1;
  logic       gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [7:0] rdata_0, rdata_1;
  logic       mem_read_n, mem_write_n;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .MEM_WORD_SIZE(8), .LOCK_MAX(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_0(req_0), .we_0(we_0), .lock_0(lock_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
    .req_1(req_1), .we_1(we_1), .lock_1(lock_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
    .mem_read_n(mem_read_n), .mem_write_n(mem_write_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // SRAM model: one-cycle read latency, contents preset to addr+1 while in reset.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 1);
      mem_rdata <= 8'h00;
    end else begin
      if (!mem_write_n) mem[mem_addr] <= mem_wdata;
      if (!mem_read_n)  mem_rdata <= mem[mem_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // c = {req, we, lock}; eg = {gnt_0, gnt_1, rvalid_0, rvalid_1}; en = {mem_read_n, mem_write_n}
  typedef struct {
    logic [2:0] c0;
    logic [7:0] a0, d0;
    logic [2:0] c1;
    logic [7:0] a1, d1;
    logic [3:0] eg;
    logic [7:0] rd0, rd1;
    logic [1:0] en;
    logic [7:0] ma, md;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] c0, input logic [7:0] a0, input logic [7:0] d0,
                              input logic [2:0] c1, input logic [7:0] a1, input logic [7:0] d1,
                              input logic [3:0] eg, input logic [7:0] rd0, input logic [7:0] rd1,
                              input logic [1:0] en, input logic [7:0] ma, input logic [7:0] md);
    vec_t v;
    v.c0 = c0; v.a0 = a0; v.d0 = d0; v.c1 = c1; v.a1 = a1; v.d1 = d1;
    v.eg = eg; v.rd0 = rd0; v.rd1 = rd1; v.en = en; v.ma = ma; v.md = md;
    return v;
  endfunction

  task automatic set0(input logic [2:0] c, input logic [7:0] a, input logic [7:0] d);
    {req_0, we_0, lock_0} = c; addr_0 = a; wdata_0 = d;
  endtask

  task automatic set1(input logic [2:0] c, input logic [7:0] a, input logic [7:0] d);
    {req_1, we_1, lock_1} = c; addr_1 = a; wdata_1 = d;
  endtask

  // Samples from the current cycle onward: counts consecutive gnt_0 beats until gnt_1, bounded.
  task automatic count_burst(input string name, input int exp_n);
    int n0 = 0;
    int gaps = 0;
    int both = 0;
    int cyc = 0;
    bit seen1 = 1'b0;
    while (!seen1 && cyc < 40) begin
      #2;
      if (gnt_0 && gnt_1) both++;
      if (gnt_1) seen1 = 1'b1;
      else if (gnt_0) n0++;
      else gaps++;
      cyc++;
      if (!seen1) @(negedge clk);
    end
    chk({name, " gnt_1 reached"}, 32'(seen1), 32'd1);
    chk({name, " gnt_0 beats"}, 32'(n0), 32'(exp_n));
    chk({name, " idle gaps"}, 32'(gaps), 32'd0);
    chk({name, " double grant"}, 32'(both), 32'd0);
  endtask

  vec_t vt [13];

  initial begin
    vt[0]  = mk(3'b100, 8'h10, 8'h00, 3'b100, 8'h20, 8'h00, 4'b1000, 8'h00, 8'h00, 2'b01, 8'h10, 8'h00);
    vt[1]  = mk(3'b100, 8'h10, 8'h00, 3'b100, 8'h20, 8'h00, 4'b0110, 8'h11, 8'h00, 2'b01, 8'h20, 8'h00);
    vt[2]  = mk(3'b100, 8'h10, 8'h00, 3'b100, 8'h20, 8'h00, 4'b1001, 8'h00, 8'h21, 2'b01, 8'h10, 8'h00);
    vt[3]  = mk(3'b100, 8'h10, 8'h00, 3'b100, 8'h20, 8'h00, 4'b0110, 8'h11, 8'h00, 2'b01, 8'h20, 8'h00);
    vt[4]  = mk(3'b000, 8'h00, 8'h00, 3'b110, 8'h03, 8'hA5, 4'b0101, 8'h00, 8'h21, 2'b10, 8'h03, 8'hA5);
    vt[5]  = mk(3'b100, 8'h03, 8'h00, 3'b000, 8'h00, 8'h00, 4'b1000, 8'h00, 8'h00, 2'b01, 8'h03, 8'h00);
    vt[6]  = mk(3'b000, 8'h55, 8'h99, 3'b000, 8'h00, 8'h00, 4'b0010, 8'hA5, 8'h00, 2'b11, 8'h00, 8'h00);
    vt[7]  = mk(3'b000, 8'h00, 8'h77, 3'b100, 8'h20, 8'h00, 4'b0100, 8'h00, 8'h00, 2'b01, 8'h20, 8'h00);
    vt[8]  = mk(3'b101, 8'h10, 8'h33, 3'b100, 8'h20, 8'h00, 4'b1001, 8'h00, 8'h21, 2'b01, 8'h10, 8'h33);
    vt[9]  = mk(3'b101, 8'h11, 8'h00, 3'b100, 8'h20, 8'h00, 4'b1010, 8'h11, 8'h00, 2'b01, 8'h11, 8'h00);
    vt[10] = mk(3'b101, 8'h12, 8'h00, 3'b100, 8'h20, 8'h00, 4'b1010, 8'h12, 8'h00, 2'b01, 8'h12, 8'h00);
    vt[11] = mk(3'b100, 8'h13, 8'h00, 3'b100, 8'h20, 8'h00, 4'b1010, 8'h13, 8'h00, 2'b01, 8'h13, 8'h00);
    vt[12] = mk(3'b100, 8'h10, 8'h00, 3'b100, 8'h20, 8'h44, 4'b0110, 8'h14, 8'h00, 2'b01, 8'h20, 8'h44);

    // Reset with every request asserted.
    rst_ni = 1'b0;
    set0(3'b101, 8'h10, 8'h00);
    set1(3'b111, 8'h20, 8'h5A);
    repeat (2) @(negedge clk);
    #2;
    chk("reset gnt_0", 32'(gnt_0), 32'd0);
    chk("reset gnt_1", 32'(gnt_1), 32'd0);
    chk("reset rvalid_0", 32'(rvalid_0), 32'd0);
    chk("reset rvalid_1", 32'(rvalid_1), 32'd0);
    chk("reset mem_read_n", 32'(mem_read_n), 32'd1);
    chk("reset mem_write_n", 32'(mem_write_n), 32'd1);
    @(negedge clk);
    rst_ni = 1'b1;
    set0(3'b000, 8'h00, 8'h00);
    set1(3'b000, 8'h00, 8'h00);

    for (int i = 0; i < 13; i++) begin
      string tag;
      @(negedge clk);
      set0(vt[i].c0, vt[i].a0, vt[i].d0);
      set1(vt[i].c1, vt[i].a1, vt[i].d1);
      #2;
      tag = $sformatf("v%0d", i);
      chk({tag, " gnt_0"}, 32'(gnt_0), 32'(vt[i].eg[3]));
      chk({tag, " gnt_1"}, 32'(gnt_1), 32'(vt[i].eg[2]));
      chk({tag, " rvalid_0"}, 32'(rvalid_0), 32'(vt[i].eg[1]));
      chk({tag, " rvalid_1"}, 32'(rvalid_1), 32'(vt[i].eg[0]));
      if (vt[i].eg[1]) chk({tag, " rdata_0"}, 32'(rdata_0), 32'(vt[i].rd0));
      if (vt[i].eg[0]) chk({tag, " rdata_1"}, 32'(rdata_1), 32'(vt[i].rd1));
      chk({tag, " mem_read_n"}, 32'(mem_read_n), 32'(vt[i].en[1]));
      chk({tag, " mem_write_n"}, 32'(mem_write_n), 32'(vt[i].en[0]));
      chk({tag, " mem_addr"}, 32'(mem_addr), 32'(vt[i].ma));
      chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(vt[i].md));
    end

    // Port 0 holds its lock indefinitely against a waiting port 1: 16 beats, then port 1.
    @(negedge clk);
    set0(3'b101, 8'h10, 8'h00);
    set1(3'b100, 8'h20, 8'h00);
    count_burst("lockmax", 16);

    // Owner goes quiet while keeping the lock: no grants, and no beats charged to it.
    @(negedge clk);
    set0(3'b101, 8'h10, 8'h00);
    set1(3'b000, 8'h20, 8'h00);
    #2;
    chk("own0 entry gnt_0", 32'(gnt_0), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set0(3'b001, 8'h10, 8'h00);
      set1(3'b100, 8'h20, 8'h00);
      #2;
      chk($sformatf("idle owner c%0d gnt_0", k), 32'(gnt_0), 32'd0);
      chk($sformatf("idle owner c%0d gnt_1", k), 32'(gnt_1), 32'd0);
    end
    @(negedge clk);
    set0(3'b101, 8'h10, 8'h00);
    count_burst("idle owner resume", 15);

    // Reset while port 1 owns the memory with a read in flight.
    @(negedge clk);
    set0(3'b000, 8'h10, 8'h00);
    set1(3'b101, 8'h20, 8'h00);
    #2;
    chk("own1 entry gnt_1", 32'(gnt_1), 32'd1);
    @(negedge clk);
    set0(3'b100, 8'h10, 8'h00);
    #2;
    chk("own1 blocks gnt_0", 32'(gnt_0), 32'd0);
    chk("own1 beat gnt_1", 32'(gnt_1), 32'd1);
    chk("own1 rvalid_1", 32'(rvalid_1), 32'd1);
    @(negedge clk);
    #1;
    chk("pre-reset rvalid_1", 32'(rvalid_1), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid reset rvalid_1", 32'(rvalid_1), 32'd0);
    chk("mid reset gnt_0", 32'(gnt_0), 32'd0);
    chk("mid reset gnt_1", 32'(gnt_1), 32'd0);
    chk("mid reset mem_read_n", 32'(mem_read_n), 32'd1);
    @(negedge clk);
    rst_ni = 1'b1;
    #2;
    chk("post reset gnt_0", 32'(gnt_0), 32'd1);
    chk("post reset gnt_1", 32'(gnt_1), 32'd0);
    chk("post reset rvalid_1", 32'(rvalid_1), 32'd0);
    @(negedge clk);
    set0(3'b000, 8'h00, 8'h00);
    set1(3'b000, 8'h00, 8'h00);
    #2;
    chk("post reset rvalid_0", 32'(rvalid_0), 32'd1);
    chk("post reset rdata_0", 32'(rdata_0), 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
